rsa_tuple_fifo: RTL and testbench
=================================

Name: rsa_tuple_fifo

Overview:
Parametrised buffer for RSA work tuples: modulus n (product of primes), private exponent d, and ciphertext c. It replaces the fixed 32-entry, free-running-counter store with a true circular FIFO that has:
- valid/ready handshakes on both sides
- full/empty tracking, occupancy and overflow reporting
- a synchronous flush
It sits between the key/cipher loader and the modular-exponentiation (decrypt) engine.

Parameters:
WIDTH, 32, bit width of each of n, d, c
DEPTH, 32, number of tuple entries; power of two, >= 2
ADDR_W, $clog2(DEPTH), pointer index width (derived, not overridden)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous flush; empties FIFO, clears overflow
in_valid  in  1  producer offers a tuple
in_ready  out  1  FIFO can accept a tuple
in_n  in  WIDTH  modulus
in_d  in  WIDTH  private key
in_c  in  WIDTH  ciphertext
out_valid  out  1  head tuple available
out_ready  in  1  consumer takes head tuple
out_n  out  WIDTH  head modulus
out_d  out  WIDTH  head private key
out_c  out  WIDTH  head ciphertext
level  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: push attempted while full

Behaviour:
- Interface decision: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n low, asynchronous):
  - wr_ptr = rd_ptr = 0, level = 0, overflow = 0, out_valid = 0.
  - in_ready is forced 0 while rst_n is low.
  - out_n/out_d/out_c read 0 while empty.
  - Storage contents are not reset.
- Pointers are ADDR_W+1 bits; the MSB distinguishes full from empty.
  - full = (level == DEPTH); empty = (level == 0).
  - Index wrap from DEPTH-1 to 0 is natural binary wrap.
- Push: in_valid && in_ready at a rising edge. Writes {in_n,in_d,in_c} to mem[wr_ptr] and increments wr_ptr.
- Pop: out_valid && out_ready at a rising edge. Increments rd_ptr.
- in_ready = !full && rst_n. It is combinational from registered state only and never depends on out_ready. When full, a same-cycle pop does not enable a push.
- out_valid = !empty. out_* = mem[rd_ptr] (first-word-fall-through).
  - A push into an empty FIFO is visible on out_* with out_valid=1 in the cycle after the push edge (latency 1).
  - Push and pop in the same cycle on a non-empty, non-full FIFO: both occur, level unchanged.
- level updates each edge by +1 on push only, -1 on pop only, 0 on both or neither.
- overflow: set at an edge where in_valid && !in_ready && rst_n. It holds until clear or reset. The rejected data is dropped and the producer must hold it.
- clear (synchronous, highest priority over push/pop):
  - Next state is pointers 0, level 0, overflow 0.
  - A push or pop in the same cycle is ignored.
- Output data is stable while out_valid && !out_ready.

Optional Feature:
RSA_FIFO_REPLAY_EN
- Defined:
  - Adds input ports commit and rewind, plus an internal cmt_ptr.
  - A pop advances rd_ptr, but the entry is freed only on commit. commit sets cmt_ptr <= rd_ptr, using the post-pop value if a pop occurs the same cycle.
  - full = (wr_ptr - cmt_ptr == DEPTH); level = wr_ptr - rd_ptr.
  - rewind sets rd_ptr <= cmt_ptr, so uncommitted tuples are re-issued after a decrypt fault.
  - rewind beats a same-cycle pop; the pop is ignored. rewind and commit together: rewind wins and cmt_ptr is unchanged.
  - clear also zeroes cmt_ptr.
- Undefined: the ports are absent, and a pop frees its entry immediately.

Decomposition:
- Package rsa_pkg:
  - RSA_WORD_W = 32, RSA_FIFO_DEPTH = 32.
  - Packed struct typedef rsa_tuple_t {n, d, c}, used for the storage word.
- One sub-module, rsa_fifo_ptr: pointer, level, full/empty and overflow control, plus cmt_ptr under the macro.
- The storage array and read mux stay in the top.

Test Plan:
1. Reset, then push 3 tuples (n=0x11,d=0x21,c=0x31 … n=0x13) with out_ready=0 -> level=3; out_n=0x11 one cycle after first push; pop 3 -> FIFO order 0x11, 0x12, 0x13, then out_valid=0.
2. Push 32 tuples -> level=32, in_ready=0; a 33rd in_valid -> overflow=1, level stays 32; pop 1 -> in_ready=1, overflow still 1 until clear.
3. Fill and drain 40 times with continuous push+pop -> level constant, data order preserved across pointer wrap.
4. Push 5, assert clear with simultaneous push and pop -> next cycle level=0, out_valid=0, overflow=0.
5. Assert rst_n=0 asynchronously mid-burst, between clock edges -> level, out_valid and in_ready go 0 immediately; after release the FIFO is empty.
6. (RSA_FIFO_REPLAY_EN) Push 4, pop 2, rewind -> head is tuple 1 again, level=4. Pop 2, commit, rewind -> head is tuple 3.

Source files
------------

// File: rtl/rsa_pkg.sv
// rsa_pkg: shared widths and the storage word for the RSA work-tuple FIFO.
//   RSA_WORD_W     : width of each tuple field (n, d, c)
//   RSA_FIFO_DEPTH : default tuple capacity
//   rsa_tuple_t    : packed {n, d, c} word held in the FIFO storage
package rsa_pkg;
  localparam int RSA_WORD_W     = 32;
  localparam int RSA_FIFO_DEPTH = 32;

  typedef struct packed {
    logic [RSA_WORD_W-1:0] n;
    logic [RSA_WORD_W-1:0] d;
    logic [RSA_WORD_W-1:0] c;
  } rsa_tuple_t;
endpackage

// File: rtl/rsa_fifo_ptr.sv
// rsa_fifo_ptr: pointer / occupancy / overflow control for rsa_tuple_fifo.
// Optional feature macro: RSA_FIFO_REPLAY_EN (adds commit/rewind and cmt_ptr).
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   clear             : synchronous flush (beats push/pop)
//   in_valid, out_ready : producer offer / consumer take
//   commit, rewind    : (replay only) free popped entries / re-issue them
//   in_ready, out_valid : handshake outputs
//   push              : write strobe for the storage array
//   wr_idx, rd_idx    : storage indices
//   level, overflow   : occupancy and sticky overflow
module rsa_fifo_ptr #(
  parameter  int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic              out_ready,
`ifdef RSA_FIFO_REPLAY_EN
  input  logic              commit,
  input  logic              rewind,
`endif
  output logic              in_ready,
  output logic              out_valid,
  output logic              push,
  output logic [ADDR_W-1:0] wr_idx,
  output logic [ADDR_W-1:0] rd_idx,
  output logic [ADDR_W:0]   level,
  output logic              overflow
);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic            full, pop;

  // Extra pointer bit lets the difference reach DEPTH, separating full from empty.
  assign level = wr_ptr_q - rd_ptr_q;

`ifdef RSA_FIFO_REPLAY_EN
  logic [ADDR_W:0] cmt_ptr_q, cmt_ptr_d, used;
  // Popped-but-uncommitted entries still occupy storage.
  assign used = wr_ptr_q - cmt_ptr_q;
  assign full = (used == LVL_FULL);
  assign pop  = out_valid && out_ready && !rewind;
`else
  assign full = (level == LVL_FULL);
  assign pop  = out_valid && out_ready;
`endif

  assign in_ready  = !full && rst_n;
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign wr_idx    = wr_ptr_q[ADDR_W-1:0];
  assign rd_idx    = rd_ptr_q[ADDR_W-1:0];
  assign overflow  = overflow_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q | (in_valid & ~in_ready);
`ifdef RSA_FIFO_REPLAY_EN
    cmt_ptr_d  = cmt_ptr_q;
`endif
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
`ifdef RSA_FIFO_REPLAY_EN
      cmt_ptr_d  = '0;
`endif
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
`ifdef RSA_FIFO_REPLAY_EN
      if (rewind)   rd_ptr_d = cmt_ptr_q;
      else if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      // Commit captures the post-pop read pointer; rewind suppresses it.
      if (commit && !rewind) cmt_ptr_d = rd_ptr_d;
`else
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
`ifdef RSA_FIFO_REPLAY_EN
      cmt_ptr_q  <= '0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
`ifdef RSA_FIFO_REPLAY_EN
      cmt_ptr_q  <= cmt_ptr_d;
`endif
    end
  end
endmodule

// File: rtl/rsa_tuple_fifo.sv
// rsa_tuple_fifo: first-word-fall-through circular FIFO of RSA tuples {n, d, c}
// between the key/cipher loader and the decrypt engine.
// Optional feature macro: RSA_FIFO_REPLAY_EN (commit/rewind replay of popped tuples).
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   clear                 : synchronous flush, also clears overflow
//   in_valid/in_ready     : producer handshake, data in_n/in_d/in_c
//   out_valid/out_ready   : consumer handshake, head data out_n/out_d/out_c (0 when empty)
//   commit, rewind        : (replay only) free popped tuples / re-issue uncommitted ones
//   level                 : occupancy 0..DEPTH
//   overflow              : sticky, push attempted while full
// WIDTH must match rsa_pkg::RSA_WORD_W since storage uses rsa_tuple_t.
module rsa_tuple_fifo
  import rsa_pkg::*;
#(
  parameter  int WIDTH  = RSA_WORD_W,
  parameter  int DEPTH  = RSA_FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_n,
  input  logic [WIDTH-1:0]  in_d,
  input  logic [WIDTH-1:0]  in_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_n,
  output logic [WIDTH-1:0]  out_d,
  output logic [WIDTH-1:0]  out_c,
`ifdef RSA_FIFO_REPLAY_EN
  input  logic              commit,
  input  logic              rewind,
`endif
  output logic [ADDR_W:0]   level,
  output logic              overflow
);
  rsa_tuple_t        mem [DEPTH];
  rsa_tuple_t        head;
  logic              push;
  logic [ADDR_W-1:0] wr_idx, rd_idx;

  rsa_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .out_ready (out_ready),
`ifdef RSA_FIFO_REPLAY_EN
    .commit    (commit),
    .rewind    (rewind),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .push      (push),
    .wr_idx    (wr_idx),
    .rd_idx    (rd_idx),
    .level     (level),
    .overflow  (overflow)
  );

  // Storage is deliberately not reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= '{n: in_n, d: in_d, c: in_c};
  end

  // Masking with out_valid keeps stale storage off the outputs when empty.
  assign head  = mem[rd_idx];
  assign out_n = out_valid ? head.n : '0;
  assign out_d = out_valid ? head.d : '0;
  assign out_c = out_valid ? head.c : '0;
endmodule

// File: tb/tb_rsa_tuple_fifo.sv
module tb_rsa_tuple_fifo;
  import rsa_pkg::*;
  localparam int W = 32;
  localparam int D = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_n = '0, in_d = '0, in_c = '0;
  logic         in_ready, out_valid, overflow;
  logic [W-1:0] out_n, out_d, out_c;
  logic [5:0]   level;
`ifdef RSA_FIFO_REPLAY_EN
  logic         commit = 1'b0;
  logic         rewind = 1'b0;
`endif

  always #5 clk = ~clk;

  rsa_tuple_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_n      (in_n),
    .in_d      (in_d),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_n     (out_n),
    .out_d     (out_d),
    .out_c     (out_c),
`ifdef RSA_FIFO_REPLAY_EN
    .commit    (commit),
    .rewind    (rewind),
`endif
    .level     (level),
    .overflow  (overflow)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  rsa_tuple_t q[$];
  logic       ovf_m = 1'b0;
  bit         sb_en = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic set_tuple(input logic [W-1:0] n, input logic [W-1:0] d, input logic [W-1:0] c);
    in_n = n; in_d = d; in_c = c;
  endtask

  // One clock: check and advance the model at the negedge, return #1 after posedge.
  task automatic step();
    bit pu, po;
    rsa_tuple_t e;
    @(negedge clk);
    if (sb_en) begin
      chk("in_ready", in_ready, 64'(q.size() < D));
      chk("out_valid", out_valid, 64'(q.size() != 0));
      chk("level", level, 64'(q.size()));
      chk("overflow", overflow, ovf_m);
      if (clear) begin
        q.delete();
        ovf_m = 1'b0;
      end else begin
        pu = in_valid && (q.size() < D);
        po = out_ready && (q.size() != 0);
        if (in_valid && !pu) ovf_m = 1'b1;
        if (po) begin
          e = q.pop_front();
          chk("out_n", out_n, e.n);
          chk("out_d", out_d, e.d);
          chk("out_c", out_c, e.c);
        end
        if (pu) q.push_back('{n: in_n, d: in_d, c: in_c});
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_level", level, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_n", out_n, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
`ifdef RSA_FIFO_REPLAY_EN
    commit = 1'b1;  // free on pop so the plain-FIFO model holds
`endif

    // T1: push 3, latency 1, FIFO order on drain
    in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      set_tuple(W'(32'h10 + k), W'(32'h20 + k), W'(32'h30 + k));
      step();
      if (k == 1) begin
        chk("t1_lat_valid", out_valid, 1);
        chk("t1_lat_n", out_n, 32'h11);
      end
    end
    in_valid = 1'b0;
    chk("t1_level", level, 3);
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    chk("t1_empty", out_valid, 0);

    // T2: fill, overflow, sticky until clear
    in_valid = 1'b1;
    for (int k = 0; k < D; k++) begin
      set_tuple(W'(32'h100 + k), W'(32'h200 + k), W'(32'h300 + k));
      step();
    end
    chk("t2_level", level, 32);
    chk("t2_in_ready", in_ready, 0);
    set_tuple(32'hdead, 32'hbeef, 32'hf00d);
    step();
    chk("t2_overflow", overflow, 1);
    chk("t2_level_hold", level, 32);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t2_ready_after_pop", in_ready, 1);
    chk("t2_ovf_sticky", overflow, 1);
    out_ready = 1'b1;
    repeat (D - 1) step();
    out_ready = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t2_ovf_cleared", overflow, 0);

    // T3: streaming push+pop across many pointer wraps
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_tuple($urandom, $urandom, $urandom);
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 80; k++) begin
      set_tuple($urandom, $urandom, $urandom);
      step();
    end
    chk("t3_level", level, 4);
    in_valid = 1'b0;
    repeat (4) step();
    out_ready = 1'b0;
    chk("t3_drained", level, 0);

    // T4: clear beats simultaneous push and pop
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_tuple(W'(32'h500 + k), W'(32'h600 + k), W'(32'h700 + k));
      step();
    end
    clear = 1'b1; out_ready = 1'b1;
    step();
    clear = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    chk("t4_level", level, 0);
    chk("t4_out_valid", out_valid, 0);
    chk("t4_overflow", overflow, 0);
    chk("t4_out_n", out_n, 0);

    // T5: asynchronous reset between edges
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_tuple(W'(32'h900 + k), W'(32'ha00 + k), W'(32'hb00 + k));
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t5_level", level, 0);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_in_ready", in_ready, 0);
    q.delete();
    ovf_m = 1'b0;
    in_valid = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    step();
    chk("t5_empty_after", out_valid, 0);

`ifdef RSA_FIFO_REPLAY_EN
    // T6: rewind re-issues uncommitted tuples
    commit = 1'b0;
    sb_en = 1'b0;
    in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      set_tuple(W'(32'h40 + k), W'(32'h50 + k), W'(32'h60 + k));
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) step();
    out_ready = 1'b0;
    chk("t6_level_pop2", level, 2);
    rewind = 1'b1; step(); rewind = 1'b0;
    chk("t6_rewind_head", out_n, 32'h41);
    chk("t6_rewind_level", level, 4);
    out_ready = 1'b1;
    repeat (2) step();
    out_ready = 1'b0;
    commit = 1'b1; step(); commit = 1'b0;
    rewind = 1'b1; step(); rewind = 1'b0;
    chk("t6_commit_head", out_n, 32'h43);
    chk("t6_commit_level", level, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
